// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and clock/baud constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int CLK_FREQ      = 50_000_000;
    localparam int BAUD_9600     = 9600;
    localparam int BAUD_CNT_9600 = CLK_FREQ / BAUD_9600;   // 5208 cycles per bit

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Parity bit for a byte; unknown modes fall back to "no parity" (bit unused).
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_NONE: p = 1'b0;
            PAR_ODD:  p = ~(^data);
            PAR_EVEN: p = ^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Enable-gated bit-period counter: counts 0..BAUD_CNT-1 and flags the terminal count.
// Held at zero while disabled so every bit period starts from a clean count.
module uart_baud_cnt #(
    parameter int BAUD_CNT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [15:0] CNT_LAST = 16'(BAUD_CNT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tc_o = en_i && (cnt_q == CNT_LAST);

    // Next count: clear when idle, wrap on terminal count, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_linjuan.sv
// Byte-wide UART transmitter: one start bit, 8 data bits LSB first, optional
// parity bit and 1 or 2 stop bits per accepted byte. All outputs are registered.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line high, tx_rdy high, waiting for tx_vld
// ST_START  | driving the start bit (0) for one bit period
// ST_DATA   | shifting out data bits 0..7, one per bit period
// ST_PARITY | driving the latched parity bit (only when parity enabled)
// ST_STOP   | driving 1 for STOP_BITS bit periods, then back to idle
module uart_tx_linjuan
    import uart_pkg::*;
#(
    parameter int BAUD_CNT  = BAUD_CNT_9600,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       tx_done,
    output logic       tx_uart
);

    localparam bit         PAR_EN    = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam logic [3:0] DATA_LAST = 4'd7;
    localparam logic [3:0] STOP_LAST = (STOP_BITS == 2) ? 4'd1 : 4'd0;

    uart_state_t state_q;
    logic [7:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic        par_q;
    logic        uart_q;
    logic        rdy_q;
    logic        done_q;

    logic        baud_en;
    logic        baud_tc;

    assign baud_en = (state_q != ST_IDLE);

    uart_baud_cnt #(
        .BAUD_CNT (BAUD_CNT)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (baud_en),
        .tc_o  (baud_tc)
    );

    // Frame sequencer: each state advances on the baud terminal count and sets
    // the line level for the following bit on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            uart_q    <= 1'b1;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_vld && rdy_q) begin
                        shift_q   <= tx_data;
                        par_q     <= parity_bit(tx_data, PARITY);
                        bit_cnt_q <= '0;
                        uart_q    <= 1'b0;
                        rdy_q     <= 1'b0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tc) begin
                        uart_q    <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tc) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            if (PAR_EN) begin
                                uart_q  <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                uart_q  <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            uart_q    <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tc) begin
                        uart_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tc) begin
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= '0;
                            rdy_q     <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    uart_q  <= 1'b1;
                    rdy_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_uart = uart_q;
    assign tx_rdy  = rdy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_linjuan.sv
// Bench for uart_tx_linjuan: three instances (8N1, 8O2, 8E1) at 4 clocks per bit,
// a frame-table model checked every cycle, plus hand-computed frame checks.
module tb_uart_tx_linjuan;

    localparam int B = 4;
    localparam int PAR_T [3] = '{0, 1, 2};
    localparam int STP_T [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] vld;
    logic [7:0] data [3];
    wire  [2:0] uart_w;
    wire  [2:0] rdy_w;
    wire  [2:0] done_w;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_linjuan #(
            .BAUD_CNT  (B),
            .PARITY    (PAR_T[g]),
            .STOP_BITS (STP_T[g])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .tx_data (data[g]),
            .tx_vld  (vld[g]),
            .tx_rdy  (rdy_w[g]),
            .tx_done (done_w[g]),
            .tx_uart (uart_w[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Model: a frame is a table of bit levels; the line shows entry elapsed/B.
    logic [2:0] m_busy;
    int         m_el [3];
    int         m_nb [3];
    logic       m_frm [3][12];
    logic [2:0] exp_uart, exp_rdy, exp_done;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i]   = 1'b0;
                m_el[i]     = 0;
                exp_uart[i] = 1'b1;
                exp_rdy[i]  = 1'b1;
                exp_done[i] = 1'b0;
            end else begin
                exp_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_el[i]++;
                    if (m_el[i] == m_nb[i] * B) begin
                        m_busy[i]   = 1'b0;
                        exp_rdy[i]  = 1'b1;
                        exp_uart[i] = 1'b1;
                        exp_done[i] = 1'b1;
                    end else begin
                        exp_uart[i] = m_frm[i][m_el[i] / B];
                    end
                end else if (vld[i]) begin
                    automatic int n    = 9;
                    automatic int ones = $countones(data[i]);
                    m_frm[i][0] = 1'b0;
                    for (int k = 0; k < 8; k++) m_frm[i][1 + k] = data[i][k];
                    if (PAR_T[i] == 1) begin
                        m_frm[i][9] = (ones % 2 == 0);
                        n = 10;
                    end else if (PAR_T[i] == 2) begin
                        m_frm[i][9] = (ones % 2 == 1);
                        n = 10;
                    end
                    for (int s = 0; s < STP_T[i]; s++) begin
                        m_frm[i][n] = 1'b1;
                        n++;
                    end
                    m_nb[i]     = n;
                    m_busy[i]   = 1'b1;
                    m_el[i]     = 0;
                    exp_uart[i] = 1'b0;
                    exp_rdy[i]  = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("line%0d", i), 32'(uart_w[i]), 32'(exp_uart[i]));
                chk($sformatf("rdy%0d", i),  32'(rdy_w[i]),  32'(exp_rdy[i]));
                chk($sformatf("done%0d", i), 32'(done_w[i]), 32'(exp_done[i]));
            end
        end
    end

    task automatic start_tx(input int i, input logic [7:0] d, output int hs);
        @(negedge clk);
        vld[i]  = 1'b1;
        data[i] = d;
        hs      = cyc + 1;
        @(negedge clk);
        vld[i]  = 1'b0;
    endtask

    // Find the start bit, sample every bit one cycle into its period, then wait for tx_done.
    task automatic capture(input int i, output logic [7:0] b, output logic pb,
                           output logic [11:0] seq, output int fall, output int done_c);
        int n;
        int nb;
        nb     = 9 + ((PAR_T[i] == 1 || PAR_T[i] == 2) ? 1 : 0) + STP_T[i];
        b      = '0;
        pb     = 1'b0;
        seq    = '0;
        fall   = -1;
        done_c = -1;
        n      = 0;
        while (uart_w[i] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (uart_w[i] !== 1'b0) begin
            chk($sformatf("start_timeout%0d", i), 32'(uart_w[i]), 32'd0);
            return;
        end
        fall = cyc;
        for (int j = 0; j < nb; j++) begin
            while (cyc < fall + j * B + 1) @(negedge clk);
            seq[j] = uart_w[i];
        end
        b  = seq[8:1];
        pb = seq[9];
        n  = 0;
        while (done_w[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done_w[i] !== 1'b1) begin
            chk($sformatf("done_timeout%0d", i), 32'(done_w[i]), 32'd1);
            return;
        end
        done_c = cyc;
    endtask

    initial begin
        logic [7:0]  b1, b2;
        logic        pb1, pb2;
        logic [11:0] s1, s2;
        int          f1, f2, d1, d2, hs;

        rst_n = 1'b0;
        vld   = '0;
        for (int i = 0; i < 3; i++) data[i] = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_line%0d", i), 32'(uart_w[i]), 32'd1);
            chk($sformatf("rst_rdy%0d", i),  32'(rdy_w[i]),  32'd1);
            chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
        end
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 0x31: line 0,1,0,0,0,1,1,0,0,1; tx_done 40 cycles after the handshake.
        start_tx(0, 8'h31, hs);
        capture(0, b1, pb1, s1, f1, d1);
        chk("lat_31",   32'(f1 - hs), 32'd0);
        chk("seq_31",   32'(s1[9:0]), 32'h262);
        chk("byte_31",  32'(b1),      32'h31);
        chk("len_31",   32'(d1 - f1), 32'd40);
        chk("rdy_31",   32'(rdy_w[0]), 32'd1);
        repeat (3) @(negedge clk);

        // Back-to-back with tx_vld held: 0xA5 then 0x5A.
        @(negedge clk);
        vld[0]  = 1'b1;
        data[0] = 8'hA5;
        @(negedge clk);
        data[0] = 8'h5A;
        capture(0, b1, pb1, s1, f1, d1);
        fork
            capture(0, b2, pb2, s2, f2, d2);
            begin
                @(negedge clk);
                vld[0] = 1'b0;
            end
        join
        chk("b2b_byte1", 32'(b1), 32'hA5);
        chk("b2b_byte2", 32'(b2), 32'h5A);
        chk("b2b_gap",   32'(f2 - d1), 32'd1);
        repeat (3) @(negedge clk);

        // Busy: data changed and tx_vld pulsed mid-frame must not disturb 0xFF.
        @(negedge clk);
        vld[0]  = 1'b1;
        data[0] = 8'hFF;
        @(negedge clk);
        vld[0]  = 1'b0;
        data[0] = 8'h00;
        fork
            capture(0, b1, pb1, s1, f1, d1);
            begin
                repeat (10) @(negedge clk);
                vld[0] = 1'b1;
                @(negedge clk);
                vld[0] = 1'b0;
                repeat (5) @(negedge clk);
                vld[0] = 1'b1;
            end
        join
        fork
            capture(0, b2, pb2, s2, f2, d2);
            begin
                @(negedge clk);
                vld[0] = 1'b0;
            end
        join
        chk("busy_byte1", 32'(b1), 32'hFF);
        chk("busy_byte2", 32'(b2), 32'h00);
        chk("busy_gap",   32'(f2 - d1), 32'd1);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 abandons the frame; 0x3C afterwards is clean.
        start_tx(0, 8'h55, hs);
        while (cyc < hs + 17) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_line", 32'(uart_w[0]), 32'd1);
        chk("midrst_rdy",  32'(rdy_w[0]),  32'd1);
        chk("midrst_done", 32'(done_w[0]), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        start_tx(0, 8'h3C, hs);
        capture(0, b1, pb1, s1, f1, d1);
        chk("post_rst_byte", 32'(b1), 32'h3C);
        chk("post_rst_len",  32'(d1 - f1), 32'd40);
        repeat (3) @(negedge clk);

        // Odd parity, two stop bits: 0x07 has three ones, parity bit 0, 12 bit periods.
        start_tx(1, 8'h07, hs);
        capture(1, b1, pb1, s1, f1, d1);
        chk("odd_byte",   32'(b1), 32'h07);
        chk("odd_parity", 32'(pb1), 32'd0);
        chk("odd_len",    32'(d1 - f1), 32'd48);
        repeat (3) @(negedge clk);

        // Even parity, one stop bit: parity bit 1, 11 bit periods.
        start_tx(2, 8'h07, hs);
        capture(2, b1, pb1, s1, f1, d1);
        chk("even_byte",   32'(b1), 32'h07);
        chk("even_parity", 32'(pb1), 32'd1);
        chk("even_len",    32'(d1 - f1), 32'd44);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
